md_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO result registers.

---
 rtl/md_unit_if.sv | 25 ++
 rtl/md_unit.sv | 175 +++++++++++++++++
 tb/tb_md_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The master drives the launch/flush side; the slave returns status and HI/LO.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Multiply writes back after MUL_LAT cycles; divide is restoring, one bit per cycle.
module md_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic     clk,
  input  logic     rst,
  md_unit_if.slave bus
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam int unsigned CNT_MAX = (WIDTH + 2 > 8) ? (WIDTH + 2) : 8;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] orig_a_q, orig_a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PW-1:0]    mul_a_c, mul_b_c, prod_c;
  logic [WIDTH:0]   rsh_c, diff_c;
  logic [WIDTH-1:0] quo_fix_c, rem_fix_c;

  // Sign/zero extend to 2*WIDTH so one unsigned multiply covers both flavours.
  assign mul_a_c = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign mul_b_c = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod_c  = mul_a_c * mul_b_c;

  // Restoring step: partial remainder shifted left with the next dividend bit.
  assign rsh_c     = {rem_q, a_q[WIDTH-1]};
  assign diff_c    = rsh_c - {1'b0, b_q};
  assign quo_fix_c = qneg_q ? -a_q : a_q;
  assign rem_fix_c = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    orig_a_d = orig_a_q;
    sgn_d    = sgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          if (!bus.op[2]) begin
            a_d      = bus.src_a;
            b_d      = bus.src_b;
            orig_a_d = bus.src_a;
            sgn_d    = ~bus.op[0];
            qneg_d   = 1'b0;
            rneg_d   = 1'b0;
            rem_d    = '0;
            cnt_d    = CW'(1);
            state_d  = bus.op[1] ? DIV : MUL;
          end else if (bus.op == 3'd4) begin
            hi_d = bus.src_a;
          end else if (bus.op == 3'd5) begin
            lo_d = bus.src_a;
          end
        end
      end

      MUL: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(MUL_LAT)) begin
          {hi_d, lo_d} = prod_c;
          done_d       = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          if (sgn_q) begin
            a_d    = a_q[WIDTH-1] ? -a_q : a_q;
            b_d    = b_q[WIDTH-1] ? -b_q : b_q;
            qneg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
            rneg_d = a_q[WIDTH-1];
          end
          cnt_d = cnt_q + CW'(1);
        end else if (cnt_q <= CW'(WIDTH + 1)) begin
          // Quotient bits shift into the dividend register as it drains.
          if (!diff_c[WIDTH]) begin
            rem_d = diff_c[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rsh_c[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end else begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = orig_a_q;
          end else begin
            lo_d = quo_fix_c;
            hi_d = rem_fix_c;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      orig_a_q <= '0;
      sgn_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      orig_a_q <= orig_a_d;
      sgn_q    <= sgn_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: one instance at WIDTH=32/MUL_LAT=4, one at WIDTH=16/MUL_LAT=1.
// Stimulus pushes expected HI/LO; a negedge monitor pops and compares on every done pulse.
module tb_md_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst32;
  logic rst16;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q32[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) if32 ();
  md_unit_if #(.WIDTH(16)) if16 ();

  md_unit #(.WIDTH(32), .MUL_LAT(4)) u32 (.clk(clk), .rst(rst32), .bus(if32));
  md_unit #(.WIDTH(16), .MUL_LAT(1)) u16 (.clk(clk), .rst(rst16), .bus(if16));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic get_busy(input bit s);
    return s ? if16.busy : if32.busy;
  endfunction

  function automatic logic [31:0] get_hi(input bit s);
    return s ? 32'(if16.hi) : if32.hi;
  endfunction

  function automatic logic [31:0] get_lo(input bit s);
    return s ? 32'(if16.lo) : if32.lo;
  endfunction

  task automatic drive(input bit s, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
    if (s) begin
      if16.start = st; if16.op = op; if16.src_a = a[15:0]; if16.src_b = b[15:0]; if16.flush = fl;
    end else begin
      if32.start = st; if32.op = op; if32.src_a = a; if32.src_b = b; if32.flush = fl;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a MULT*/DIV* op, scramble the operand inputs, and measure busy length.
  task automatic run_op(input bit s, input string nm, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int ebusy, input bit intrude);
    int n;
    string tag;
    exp_t e;
    n   = 0;
    tag = $sformatf("%s_w%0d", nm, s ? 16 : 32);
    e.hi = ehi;
    e.lo = elo;
    if (s) q16.push_back(e); else q32.push_back(e);
    drive(s, 1'b1, op, a, b, 1'b0);
    step();
    drive(s, 1'b0, 3'd7, ~a, ~b, 1'b0);
    while (get_busy(s) && n < 100) begin
      if (intrude && n == 0) drive(s, 1'b1, 3'd3, 32'd5, 32'd3, 1'b0);
      step();
      if (intrude && n == 0) drive(s, 1'b0, 3'd7, ~a, ~b, 1'b0);
      n++;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(ebusy));
  endtask

  task automatic mt(input bit s, input logic [2:0] op, input logic [31:0] d);
    drive(s, 1'b1, op, d, 32'd0, 1'b0);
    step();
    drive(s, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    chk($sformatf("mt%0d_busy_w%0d", op, s ? 16 : 32), 32'(get_busy(s)), 32'd0);
    if (op == 3'd4) chk($sformatf("mthi_w%0d", s ? 16 : 32), get_hi(s), d);
    else            chk($sformatf("mtlo_w%0d", s ? 16 : 32), get_lo(s), d);
  endtask

  // Flush during busy cycle 'at'; HI/LO must keep their prior values and no done may follow.
  task automatic flush_op(input bit s, input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int at,
                          input logic [31:0] ehi, input logic [31:0] elo);
    string tag;
    tag = $sformatf("%s_w%0d", nm, s ? 16 : 32);
    drive(s, 1'b1, op, a, b, 1'b0);
    step();
    drive(s, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i < at; i++) step();
    chk({tag, "_busy_before"}, 32'(get_busy(s)), 32'd1);
    drive(s, 1'b0, 3'd7, 32'd0, 32'd0, 1'b1);
    step();
    drive(s, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    chk({tag, "_busy_after"}, 32'(get_busy(s)), 32'd0);
    chk({tag, "_hi"}, get_hi(s), ehi);
    chk({tag, "_lo"}, get_lo(s), elo);
    step();
    step();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (if32.done === 1'b1) begin
      if (q32.size() == 0) begin
        n_chk++;
        $display("FAIL done_w32_unexpected: got done=1 want done=0");
      end else begin
        e = q32.pop_front();
        chk("done_busy_w32", 32'(if32.busy), 32'd0);
        chk("hi_w32", if32.hi, e.hi);
        chk("lo_w32", if32.lo, e.lo);
      end
    end
    if (if16.done === 1'b1) begin
      if (q16.size() == 0) begin
        n_chk++;
        $display("FAIL done_w16_unexpected: got done=1 want done=0");
      end else begin
        e = q16.pop_front();
        chk("done_busy_w16", 32'(if16.busy), 32'd0);
        chk("hi_w16", 32'(if16.hi), e.hi);
        chk("lo_w16", 32'(if16.lo), e.lo);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] m, mn;
    int lm, ld;
    rst32 = 1'b1;
    rst16 = 1'b1;
    drive(1'b0, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    step();
    step();
    rst32 = 1'b0;
    rst16 = 1'b0;
    step();
    for (int si = 0; si < 2; si++) begin
      chk($sformatf("rst_busy_w%0d", si ? 16 : 32), 32'(get_busy(si[0])), 32'd0);
      chk($sformatf("rst_done_w%0d", si ? 16 : 32), si ? 32'(if16.done) : 32'(if32.done), 32'd0);
      chk($sformatf("rst_hi_w%0d", si ? 16 : 32), get_hi(si[0]), 32'd0);
      chk($sformatf("rst_lo_w%0d", si ? 16 : 32), get_lo(si[0]), 32'd0);
    end

    for (int si = 0; si < 2; si++) begin
      bit s;
      s  = si[0];
      m  = s ? 32'h0000FFFF : 32'hFFFFFFFF;
      mn = s ? 32'h00008000 : 32'h80000000;
      lm = s ? 1 : 4;
      ld = s ? 18 : 34;

      run_op(s, "mult_neg",  3'd0, m, 32'd2, m, m - 32'd1, lm, 1'b0);
      run_op(s, "multu_big", 3'd1, m, 32'd2, 32'd1, m - 32'd1, lm, 1'b0);
      run_op(s, "mult_min",  3'd0, mn, mn, mn >> 1, 32'd0, lm, 1'b0);
      run_op(s, "div_neg7",  3'd2, m - 32'd6, 32'd2, m, m - 32'd2, ld, 1'b0);
      run_op(s, "div_7_m2",  3'd2, 32'd7, m - 32'd1, 32'd1, m - 32'd2, ld, 1'b0);
      run_op(s, "divu_7_2",  3'd3, 32'd7, 32'd2, 32'd1, 32'd3, ld, 1'b0);
      run_op(s, "divu_z",    3'd3, 32'd7, 32'd0, 32'd7, m, ld, 1'b0);
      run_op(s, "div_z_neg", 3'd2, m - 32'd6, 32'd0, m - 32'd6, m, ld, 1'b0);
      run_op(s, "div_ovf",   3'd2, mn, m, 32'd0, mn, ld, 1'b0);
      run_op(s, "divu_m_1",  3'd3, m, 32'd1, 32'd0, m, ld, 1'b0);
      run_op(s, "divu_m_mn", 3'd3, m, mn, m >> 1, 32'd1, ld, 1'b0);
      step();

      mt(s, 3'd4, 32'h1234);
      mt(s, 3'd5, 32'h5678);
      flush_op(s, "flush_div", 3'd2, 32'd100, 32'd7, 10, 32'h1234, 32'h5678);
      flush_op(s, "flush_wb",  3'd0, 32'd3, 32'd5, lm, 32'h1234, 32'h5678);

      drive(s, 1'b1, 3'd4, 32'h0009, 32'd0, 1'b1);
      step();
      drive(s, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      chk($sformatf("flush_mthi_hi_w%0d", s ? 16 : 32), get_hi(s), 32'h1234);
      chk($sformatf("flush_mthi_busy_w%0d", s ? 16 : 32), 32'(get_busy(s)), 32'd0);

      run_op(s, "multu_intr", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, lm, 1'b1);
      step();

      mt(s, 3'd4, 32'h00AB);
      drive(s, 1'b1, 3'd0, 32'd3, 32'd5, 1'b0);
      step();
      drive(s, 1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
      if (!s) step();
      #2;
      if (s) rst16 = 1'b1; else rst32 = 1'b1;
      #1;
      chk($sformatf("rst_mid_busy_w%0d", s ? 16 : 32), 32'(get_busy(s)), 32'd0);
      chk($sformatf("rst_mid_hi_w%0d", s ? 16 : 32), get_hi(s), 32'd0);
      chk($sformatf("rst_mid_lo_w%0d", s ? 16 : 32), get_lo(s), 32'd0);
      #2;
      if (s) rst16 = 1'b0; else rst32 = 1'b0;
      repeat (6) step();
    end

    chk("q32_drained", 32'(q32.size()), 32'd0);
    chk("q16_drained", 32'(q16.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
